// File: rtl/timer_core_gen_pkg.sv
// Shared types and constants for the timer core: FSM state encoding,
// flag bit positions and count-direction codes.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLG_OVF = 0;
    localparam int FLG_UDF = 1;
    localparam int FLG_CMP = 2;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/timer_core_gen_if.sv
// Configuration/status bundle between the APB register block (master)
// and the timer core (slave).
interface timer_core_gen_if
    import timer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int CKS_W = 2
);

    logic             en;
    logic [CKS_W-1:0] cks;
    logic             dir;
    logic             oneshot;
    logic             cfg_reconf;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cmp_val;
    logic [2:0]       clr_flags;
    logic [2:0]       irq_en;

    logic [CNT_W-1:0] cnt;
    logic             count_en;
    logic [2:0]       flags;
    logic [1:0]       state_o;
    logic             irq;

    modport master (
        output en, cks, dir, oneshot, cfg_reconf, load, load_val,
               cmp_val, clr_flags, irq_en,
        input  cnt, count_en, flags, state_o, irq
    );

    modport slave (
        input  en, cks, dir, oneshot, cfg_reconf, load, load_val,
               cmp_val, clr_flags, irq_en,
        output cnt, count_en, flags, state_o, irq
    );

endinterface

// File: rtl/timer_core_gen_prescaler.sv
// Power-of-two prescaler: free-running ps_cnt while running, one-cycle
// tick whenever the low (cks+1) bits of ps_cnt are all ones.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int CKS_W = 2
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             run,
    input  logic [CKS_W-1:0] cks,
    input  logic             cfg_reconf,
    output logic             count_en
);

    localparam int PS_W = 2 ** CKS_W;

    logic [PS_W-1:0] ps_cnt_q;
    logic [PS_W-1:0] ps_cnt_d;
    logic [PS_W-1:0] tick_mask;

    // Bits 0..cks participate in the tick; cks only masks, so a change of
    // cks without cfg_reconf applies at once to the running count.
    always_comb begin
        tick_mask = '0;
        for (int i = 0; i < PS_W; i++) begin
            tick_mask[i] = (i <= int'(cks));
        end
    end

    // Outside RUN the count is parked at zero, so every entry into RUN
    // starts a fresh prescaler period without a separate restart input.
    always_comb begin
        ps_cnt_d = ps_cnt_q + PS_W'(1);
        if (cfg_reconf || !run) begin
            ps_cnt_d = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

    assign count_en = run && ((ps_cnt_q & tick_mask) == tick_mask) && !cfg_reconf;

endmodule

// File: rtl/timer_core_gen.sv
// Timer core: up/down counter stepped by the prescaler tick, one-shot or
// auto-reload operation, compare match, sticky flags and registered irq.
module timer_core_gen
    import timer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int CKS_W = 2
) (
    input  logic              pclk,
    input  logic              preset_n,
    timer_core_gen_if.slave   bus
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       flags_q;
    logic [2:0]       flags_d;
    logic [2:0]       flag_set;
    logic             irq_q;
    logic             irq_d;
    logic             run;
    logic             count_en;
    logic             wrap;

    function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] v,
                                                   input logic            d);
        return (d == DIR_DN) ? v - CNT_W'(1) : v + CNT_W'(1);
    endfunction

    function automatic logic at_limit(input logic [CNT_W-1:0] v,
                                      input logic            d);
        return (d == DIR_DN) ? (v == '0) : (v == '1);
    endfunction

    assign run = (state_q == RUN);

    timer_prescaler #(
        .CKS_W (CKS_W)
    ) u_prescaler (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .run        (run),
        .cks        (bus.cks),
        .cfg_reconf (bus.cfg_reconf),
        .count_en   (count_en)
    );

    // A load overrides the tick entirely: no step, no wrap, no compare.
    always_comb begin
        cnt_d    = cnt_q;
        flag_set = '0;
        wrap     = 1'b0;
        if (bus.load) begin
            cnt_d = bus.load_val;
        end else if (count_en) begin
            cnt_d             = step_cnt(cnt_q, bus.dir);
            wrap              = at_limit(cnt_q, bus.dir);
            flag_set[FLG_OVF] = wrap && (bus.dir == DIR_UP);
            flag_set[FLG_UDF] = wrap && (bus.dir == DIR_DN);
            flag_set[FLG_CMP] = (cnt_d == bus.cmp_val);
        end
    end

    // Set beats clear on a collision; irq follows the flags one cycle late.
    always_comb begin
        flags_d = (flags_q & ~bus.clr_flags) | flag_set;
        irq_d   = |(flags_q & bus.irq_en);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = RUN;
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (bus.oneshot && wrap) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.count_en = count_en;
    assign bus.flags    = flags_q;
    assign bus.state_o  = state_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_timer_core_gen.sv
// Directed and randomized bench for timer_core_gen against a cycle-level
// behavioural model of the timer rules.
module tb_timer_core_gen;
    import timer_pkg::*;

    localparam int CNT_W = 16;
    localparam int CKS_W = 2;
    localparam int MAXV  = 65535;

    logic pclk = 1'b0;
    logic preset_n;

    timer_core_gen_if #(.CNT_W(CNT_W), .CKS_W(CKS_W)) bus ();

    timer_core_gen #(.CNT_W(CNT_W), .CKS_W(CKS_W)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: state code, count, cycles spent in RUN since the last restart
    int         m_state;
    int         m_cnt;
    int         m_phase;
    logic [2:0] m_flags;
    logic       m_irq;
    bit         last_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pred_tick();
        int period;
        period = 1 << (int'(bus.cks) + 1);
        return (m_state == 1) && !bus.cfg_reconf && (((m_phase + 1) % period) == 0);
    endfunction

    task automatic model_edge();
        bit         tk;
        bit         wrapped;
        int         nc;
        int         ns;
        logic [2:0] set;
        tk = pred_tick();
        if (!preset_n) begin
            m_state = 0; m_cnt = 0; m_phase = 0; m_flags = 3'b000; m_irq = 1'b0;
            return;
        end
        set = 3'b000; wrapped = 1'b0; nc = m_cnt;
        if (bus.load) begin
            nc = int'(bus.load_val);
        end else if (tk) begin
            if (bus.dir == 1'b0) begin
                if (m_cnt == MAXV) begin nc = 0; set[0] = 1'b1; wrapped = 1'b1; end
                else nc = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin nc = MAXV; set[1] = 1'b1; wrapped = 1'b1; end
                else nc = m_cnt - 1;
            end
            if (nc == int'(bus.cmp_val)) set[2] = 1'b1;
        end
        m_irq   = |(m_flags & bus.irq_en);
        m_flags = (m_flags & ~bus.clr_flags) | set;
        ns = m_state;
        if (m_state == 0 && bus.en) ns = 1;
        else if (m_state == 1 && !bus.en) ns = 0;
        else if (m_state == 1 && bus.oneshot && wrapped) ns = 2;
        else if (m_state == 2 && !bus.en) ns = 0;
        m_phase = (m_state == 1 && !bus.cfg_reconf) ? m_phase + 1 : 0;
        m_state = ns;
        m_cnt   = nc;
    endtask

    task automatic cycle();
        @(negedge pclk);
        last_tick = bus.count_en;
        chk("count_en", 32'(bus.count_en), 32'(pred_tick()));
        @(posedge pclk);
        model_edge();
        #1;
        chk("cnt", 32'(bus.cnt), 32'(m_cnt));
        chk("flags", 32'(bus.flags), 32'(m_flags));
        chk("state", 32'(bus.state_o), 32'(m_state));
        chk("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_tick && n < 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ticks;
        preset_n = 1'b0;
        bus.en = 1'b0; bus.cks = '0; bus.dir = 1'b0; bus.oneshot = 1'b0;
        bus.cfg_reconf = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.cmp_val = '0;
        bus.clr_flags = '0; bus.irq_en = '0;
        m_state = 0; m_cnt = 0; m_phase = 0; m_flags = 3'b000; m_irq = 1'b0;
        @(posedge pclk);
        #1;

        // Reset state
        cycle();
        chk("rst_cnt", 32'(bus.cnt), 32'h0);
        chk("rst_state", 32'(bus.state_o), 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_count_en", 32'(bus.count_en), 32'h0);

        // Tick period for every clock select
        preset_n = 1'b1; bus.en = 1'b1;
        cycle();
        chk("enter_run", 32'(bus.state_o), 32'h1);
        for (int k = 0; k < 4; k++) begin
            bus.cks = 2'(k); bus.cfg_reconf = 1'b1;
            cycle();
            bus.cfg_reconf = 1'b0;
            for (int rep = 0; rep < 2; rep++) begin
                wait_tick(n);
                chk($sformatf("period_cks%0d_%0d", k, rep), 32'(n), 32'(1 << (k + 1)));
            end
        end

        // Up wrap, auto-reload, irq on ovf
        bus.cks = 2'd0; bus.cfg_reconf = 1'b1; bus.irq_en = 3'b001; bus.clr_flags = 3'b111;
        cycle();
        bus.cfg_reconf = 1'b0; bus.clr_flags = 3'b000;
        bus.load = 1'b1; bus.load_val = 16'hFFFE;
        cycle();
        bus.load = 1'b0;
        chk("wrap_load", 32'(bus.cnt), 32'hFFFE);
        ticks = 0; n = 0;
        while (ticks < 3 && n < 40) begin
            cycle(); n++;
            if (last_tick) begin
                if (ticks == 0) begin
                    chk("wrap_t0_cnt", 32'(bus.cnt), 32'hFFFF);
                    chk("wrap_t0_ovf", 32'(bus.flags[0]), 32'h0);
                end else if (ticks == 1) begin
                    chk("wrap_t1_cnt", 32'(bus.cnt), 32'h0);
                    chk("wrap_t1_ovf", 32'(bus.flags[0]), 32'h1);
                    chk("wrap_t1_state", 32'(bus.state_o), 32'h1);
                    chk("wrap_t1_irq0", 32'(bus.irq), 32'h0);
                    cycle();
                    chk("wrap_irq1", 32'(bus.irq), 32'h1);
                end else begin
                    chk("wrap_t2_cnt", 32'(bus.cnt), 32'h1);
                    chk("wrap_t2_state", 32'(bus.state_o), 32'h1);
                end
                ticks++;
            end
        end
        chk("wrap_ticks", 32'(ticks), 32'd3);

        // Down count, one-shot
        bus.clr_flags = 3'b111; bus.irq_en = 3'b000; bus.dir = 1'b1; bus.oneshot = 1'b1;
        bus.load = 1'b1; bus.load_val = 16'd2;
        cycle();
        bus.clr_flags = 3'b000; bus.load = 1'b0;
        wait_tick(n); chk("dn_t0", 32'(bus.cnt), 32'h1);
        wait_tick(n); chk("dn_t1", 32'(bus.cnt), 32'h0);
        wait_tick(n); chk("dn_t2", 32'(bus.cnt), 32'hFFFF);
        chk("dn_done", 32'(bus.state_o), 32'h2);
        chk("dn_udf", 32'(bus.flags[1]), 32'h1);
        ticks = 0;
        repeat (20) begin
            cycle();
            if (last_tick) ticks++;
        end
        chk("done_no_tick", 32'(ticks), 32'h0);
        chk("done_hold", 32'(bus.cnt), 32'hFFFF);
        bus.en = 1'b0;
        cycle();
        chk("done_to_idle", 32'(bus.state_o), 32'h0);

        // Compare match and flag clear collision
        bus.oneshot = 1'b0; bus.dir = 1'b0; bus.cmp_val = 16'd5; bus.clr_flags = 3'b111;
        bus.load = 1'b1; bus.load_val = 16'd0; bus.en = 1'b1;
        cycle();
        bus.load = 1'b0; bus.clr_flags = 3'b000;
        n = 0;
        while (bus.cnt != 16'd5 && n < 40) begin cycle(); n++; end
        chk("cmp_reach", 32'(bus.cnt), 32'd5);
        chk("cmp_set", 32'(bus.flags[2]), 32'h1);
        bus.load = 1'b1; bus.load_val = 16'd4;
        cycle();
        bus.load = 1'b0;
        n = 0;
        while (!pred_tick() && n < 40) begin cycle(); n++; end
        bus.clr_flags = 3'b100;
        cycle();
        bus.clr_flags = 3'b000;
        chk("cmp_rematch_cnt", 32'(bus.cnt), 32'd5);
        chk("cmp_set_wins", 32'(bus.flags[2]), 32'h1);
        n = 0;
        while (pred_tick() && n < 40) begin cycle(); n++; end
        bus.clr_flags = 3'b100;
        cycle();
        bus.clr_flags = 3'b000;
        chk("cmp_cleared", 32'(bus.flags[2]), 32'h0);

        // Load colliding with a tick
        n = 0;
        while (!pred_tick() && n < 40) begin cycle(); n++; end
        bus.load = 1'b1; bus.load_val = 16'h1234;
        cycle();
        bus.load = 1'b0;
        chk("coll_tick_seen", 32'(last_tick), 32'h1);
        chk("coll_cnt", 32'(bus.cnt), 32'h1234);
        wait_tick(n);
        chk("coll_period", 32'(n), 32'd2);
        chk("coll_next", 32'(bus.cnt), 32'h1235);

        // Reset during RUN with a flag set
        bus.load = 1'b1; bus.load_val = 16'hFFFF;
        cycle();
        bus.load = 1'b0;
        wait_tick(n);
        chk("pre_rst_ovf", 32'(bus.flags[0]), 32'h1);
        bus.cks = 2'd1; preset_n = 1'b0;
        cycle();
        preset_n = 1'b1;
        chk("mid_rst_cnt", 32'(bus.cnt), 32'h0);
        chk("mid_rst_flags", 32'(bus.flags), 32'h0);
        chk("mid_rst_state", 32'(bus.state_o), 32'h0);
        chk("mid_rst_irq", 32'(bus.irq), 32'h0);
        chk("mid_rst_count_en", 32'(bus.count_en), 32'h0);
        cycle();
        chk("rst_rerun", 32'(bus.state_o), 32'h1);
        wait_tick(n);
        chk("rst_first_tick", 32'(n), 32'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            preset_n       = ($urandom_range(0, 99) != 0);
            bus.en         = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus.cks = 2'($urandom_range(0, 3));
            bus.cfg_reconf = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
            bus.oneshot    = ($urandom_range(0, 7) == 0);
            bus.load       = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 4))
                0: bus.load_val = 16'h0000;
                1: bus.load_val = 16'h0001;
                2: bus.load_val = 16'hFFFE;
                3: bus.load_val = 16'hFFFF;
                default: bus.load_val = 16'($urandom);
            endcase
            bus.cmp_val    = ($urandom_range(0, 2) == 0) ? 16'(m_cnt + 1) : 16'(m_cnt - 1);
            bus.clr_flags  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            bus.irq_en     = 3'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
